// File: rtl/accel_init_pkg.sv
// rtl/accel_init_pkg.sv - shared types and constants for the accelerator initiator
package accel_init_pkg;

    localparam int FLOAT_W = 32;
    localparam logic [FLOAT_W-1:0] QNAN_F32 = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

endpackage

// File: rtl/accel_init_timer.sv
// rtl/accel_init_timer.sv - WAIT-state watchdog counter, built only with ACCEL_TIMEOUT_EN
`ifdef ACCEL_TIMEOUT_EN
module accel_init_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clk_en_i,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    // Cleared while the start pulse is out, then counts WAIT edges; expire marks the last allowed edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clk_en_i) begin
            if (load_i) begin
                cnt_q <= '0;
            end else if (count_i && !expire_o) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign expire_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/accel_initiator.sv
// rtl/accel_initiator.sv - operand/result handshake FSM driving a start/done accelerator; optional watchdog via ACCEL_TIMEOUT_EN
module accel_initiator
    import accel_init_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clk_en_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [FLOAT_W-1:0] in_data_i,
    output logic               acc_start_o,
    output logic [FLOAT_W-1:0] acc_x_o,
    input  logic               acc_done_i,
    input  logic [FLOAT_W-1:0] acc_y_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [FLOAT_W-1:0] out_data_o,
    output logic [CNT_W-1:0]   op_count_o,
    output logic               busy_o,
    output logic               timeout_err_o
);

    state_e             state_q;
    logic               in_ready_q;
    logic               acc_start_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [FLOAT_W-1:0] acc_x_q;
    logic [FLOAT_W-1:0] out_data_q;
    logic [CNT_W-1:0]   op_count_q;
    logic [CNT_W-1:0]   op_count_d;

    // Counter simply rolls over; no overflow indication is wanted
    assign op_count_d = op_count_q + 1'b1;

`ifdef ACCEL_TIMEOUT_EN
    logic timeout_err_q;
    logic tmr_expire;

    accel_init_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clk_en_i (clk_en_i),
        .load_i   (state_q == ST_ISSUE),
        .count_i  (state_q == ST_WAIT),
        .expire_o (tmr_expire)
    );

    // Sticky abort flag; only a reset clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_err_q <= 1'b0;
        end else if (clk_en_i && state_q == ST_WAIT && !acc_done_i && tmr_expire) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_err_o      = 1'b0;
`endif

    // Main FSM; all handshake outputs are registered alongside the state so they change only on enabled edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            acc_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_x_q     <= '0;
            out_data_q  <= '0;
            op_count_q  <= '0;
        end else if (clk_en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        acc_x_q     <= in_data_i;
                        in_ready_q  <= 1'b0;
                        acc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A done seen while the start pulse is still out belongs to nothing we issued
                    acc_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done on the same edge as the watchdog expiry wins
                    if (acc_done_i) begin
                        out_data_q  <= acc_y_i;
                        op_count_q  <= op_count_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DELIVER;
                    end
`ifdef ACCEL_TIMEOUT_EN
                    else if (tmr_expire) begin
                        out_data_q  <= QNAN_F32;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DELIVER;
                    end
`endif
                end
                ST_DELIVER: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign acc_start_o = acc_start_q;
    assign acc_x_o     = acc_x_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign op_count_o  = op_count_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_accel_initiator.sv
// tb/tb_accel_initiator.sv - scoreboard bench for accel_initiator with a start/done accelerator stub
module tb_accel_initiator;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        acc_start;
    logic [31:0] acc_x;
    logic        acc_done;
    logic [31:0] acc_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  op_count;
    logic        busy;
    logic        timeout_err;

    accel_initiator #(
        .TIMEOUT_CYC (8),
        .CNT_W       (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clk_en_i      (clk_en),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .acc_start_o   (acc_start),
        .acc_x_o       (acc_x),
        .acc_done_i    (acc_done),
        .acc_y_i       (acc_y),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .op_count_o    (op_count),
        .busy_o        (busy),
        .timeout_err_o (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accelerator stub: y = x ^ mask, done pulse sampled stub_delay edges after the accepted start edge
    int          stub_delay = 3;
    logic [31:0] stub_mask  = 32'h0;
    bit          stub_never = 1'b0;
    int          pend       = 0;
    int          start_rises   = 0;
    int          start_accepts = 0;
    logic        start_prev = 1'b0;

    initial begin
        acc_done = 1'b0;
        acc_y    = 32'h0;
    end

    always @(posedge clk) begin
        acc_done <= 1'b0;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) acc_done <= 1'b1;
        end
        if (acc_start && clk_en && rst_n) begin
            start_accepts++;
            acc_y <= acc_x ^ stub_mask;
            if (!stub_never) begin
                if (stub_delay <= 1) acc_done <= 1'b1;
                else pend <= stub_delay - 1;
            end
        end
        if (acc_start && !start_prev) start_rises++;
        start_prev <= acc_start;
    end

    // Scoreboard
    typedef struct {
        logic [31:0] data;
        logic        terr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] cnt_model  = 4'd0;
    logic       terr_model = 1'b0;
    time        last_t = 0;
    time        prev_t = 0;

    always @(negedge clk) begin
        if (rst_n && clk_en && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("op_count", {28'd0, op_count}, {28'd0, e.cnt});
                check("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [31:0] exp_d, input bit is_to);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        prev_t = last_t;
        last_t = $time;
        if (!is_to) cnt_model = cnt_model + 4'd1;
        terr_model = terr_model | is_to;
        e.data = exp_d;
        e.terr = terr_model;
        e.cnt  = cnt_model;
        sb_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          delay;
        int          hold;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          s0;
        int          r0;
        logic [31:0] held;

        vecs[0] = '{32'h4360_0000, 32'h0000_0000, 3, 0};
        vecs[1] = '{32'h3F80_0000, 32'h0000_FFFF, 1, 0};
        vecs[2] = '{32'hC049_0FDB, 32'h8000_0000, 5, 2};
        vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 2, 0};
        vecs[4] = '{32'h7F7F_FFFF, 32'h0000_0000, 1, 3};

        rst_n     = 1'b1;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #3 rst_n  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acc_start", {31'd0, acc_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_acc_x", acc_x, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations
        for (int i = 0; i < 5; i++) begin
            stub_delay = vecs[i].delay;
            stub_mask  = vecs[i].mask;
            out_ready  = (vecs[i].hold == 0);
            send(vecs[i].data, vecs[i].data ^ vecs[i].mask, 1'b0);
            if (vecs[i].hold > 0) begin
                wait_out_valid();
                repeat (vecs[i].hold) @(negedge clk);
                out_ready = 1'b1;
            end
            wait_drain();
            if (i == 0) check("first_op_starts", start_accepts, 32'd1);
        end

        // Minimum latency: start during E0..E1, out_valid from E2
        stub_delay = 1;
        stub_mask  = 32'h0;
        send(32'h4120_0000, 32'h4120_0000, 1'b0);
        check("lat_start_hi", {31'd0, acc_start}, 32'd1);
        check("lat_acc_x", acc_x, 32'h4120_0000);
        check("lat_in_ready_lo", {31'd0, in_ready}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("lat_start_lo", {31'd0, acc_start}, 32'd0);
        check("lat_wait_no_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        wait_drain();

        // Back-pressure: result held, no new operand taken
        stub_delay = 2;
        out_ready  = 1'b0;
        send(32'hBF00_0000, 32'hBF00_0000, 1'b0);
        wait_out_valid();
        held = out_data;
        s0 = start_accepts;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", out_data, 32'hBF00_0000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("bp_no_restart", start_accepts - s0, 32'd0);
        check("bp_stable_vs_first", out_data, held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Clock-enable freeze during ISSUE
        stub_delay = 3;
        s0 = start_accepts;
        r0 = start_rises;
        send(32'h4049_0FDB, 32'h4049_0FDB, 1'b0);
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ce_start_held", {31'd0, acc_start}, 32'd1);
        end
        clk_en = 1'b1;
        wait_drain();
        check("ce_start_rises", start_rises - r0, 32'd1);
        check("ce_start_accepts", start_accepts - s0, 32'd1);

        // Reset while waiting for done: operation abandoned
        stub_delay = 5;
        send(32'h4000_0000, 32'h4000_0000, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        cnt_model  = 4'd0;
        terr_model = 1'b0;
        #1;
        check("wrst_busy", {31'd0, busy}, 32'd0);
        check("wrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("wrst_acc_x", acc_x, 32'd0);
        check("wrst_op_count", {28'd0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("wrst_late_done_valid", {31'd0, out_valid}, 32'd0);
        check("wrst_late_done_count", {28'd0, op_count}, 32'd0);
        check("wrst_late_done_data", out_data, 32'd0);

        // 17 back-to-back ops through a 4-bit counter
        stub_delay = 1;
        stub_mask  = 32'h0;
        for (int k = 0; k < 17; k++) begin
            send(32'h3F00_0000 + k, 32'h3F00_0000 + k, 1'b0);
        end
        wait_drain();
        check("wrap_op_count", {28'd0, op_count}, 32'd1);
        check("throughput_cycles", 32'(last_t - prev_t), 32'd40);

`ifdef ACCEL_TIMEOUT_EN
        // Watchdog abort, then done on exactly the expiry edge
        stub_never = 1'b1;
        send(32'h4110_0000, 32'h7FC0_0000, 1'b1);
        wait_drain();
        check("to_flag", {31'd0, timeout_err}, 32'd1);
        check("to_count", {28'd0, op_count}, 32'd1);
        stub_never = 1'b0;
        stub_delay = 8;
        send(32'h4120_0000, 32'h4120_0000, 1'b0);
        wait_drain();
        check("to_edge_count", {28'd0, op_count}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
